// File: rtl/i2c_cmd_sequencer.sv
// I2C command sequencer: queues write/read commands and launches them one at a time into master_device,
// watching the shared bus for STOP to retire each one. Define I2C_SEQ_RETRY_EN to retry once on timeout.
module i2c_cmd_sequencer #(
  parameter int DEPTH     = 4,
  parameter int EN_CYCLES = 5,
  parameter int TIMEOUT   = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [6:0]                 cmd_addr,
  input  logic                       cmd_rw,
  input  logic [7:0]                 cmd_data,
  output logic                       enable,
  output logic [6:0]                 address_in,
  output logic                       rw,
  output logic [7:0]                 data_in,
  input  logic                       scl,
  input  logic                       sda,
  output logic                       busy,
  output logic                       txn_done,
  output logic                       timeout_err,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int CMD_W = 16;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [15:0] EN_LAST = 16'(EN_CYCLES - 1);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT_STOP = 2'd2} state_t;

  logic [CMD_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s, pop_s;

  logic scl_meta_r, scl_sync_r, sda_meta_r, sda_sync_r, sda_prev_r;
  logic stop_s;

  state_t           state_r, state_nxt;
  logic [15:0]      ctr_r, ctr_nxt;
  logic             enable_r, enable_nxt;
  logic             done_r, done_nxt;
  logic             terr_r, terr_nxt;
  logic [CMD_W-1:0] launch_r;
`ifdef I2C_SEQ_RETRY_EN
  logic             retry_r, retry_nxt;
`endif

  assign cmd_ready  = (count_r < DEPTH_C);
  assign push_s     = cmd_valid & cmd_ready;
  assign fifo_count = count_r;
  assign busy       = (state_r != IDLE);
  assign enable     = enable_r;
  assign txn_done   = done_r;
  assign timeout_err = terr_r;
  assign {address_in, rw, data_in} = launch_r;

  // FIFO storage; contents are only observed after a pop, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {cmd_addr, cmd_rw, cmd_data};
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Bus synchronisers; idle bus level is high so flops reset to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_meta_r <= scl;
      scl_sync_r <= scl_meta_r;
      sda_meta_r <= sda;
      sda_sync_r <= sda_meta_r;
      sda_prev_r <= sda_sync_r;
    end
  end

  // START is informational only, so only STOP is decoded
  assign stop_s = scl_sync_r & ~sda_prev_r & sda_sync_r;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      ctr_r    <= 16'd0;
      enable_r <= 1'b0;
      done_r   <= 1'b0;
      terr_r   <= 1'b0;
      launch_r <= {CMD_W{1'b0}};
`ifdef I2C_SEQ_RETRY_EN
      retry_r  <= 1'b0;
`endif
    end else begin
      state_r  <= state_nxt;
      ctr_r    <= ctr_nxt;
      enable_r <= enable_nxt;
      done_r   <= done_nxt;
      terr_r   <= terr_nxt;
      if (pop_s) launch_r <= mem_r[rd_ptr_r];
`ifdef I2C_SEQ_RETRY_EN
      retry_r  <= retry_nxt;
`endif
    end
  end

  // Next-state logic; STOP takes priority over the timeout check
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (count_r != {CNT_W{1'b0}}) state_nxt = LAUNCH;
        else                          state_nxt = IDLE;
      end
      LAUNCH: begin
        if (ctr_r == EN_LAST) state_nxt = WAIT_STOP;
        else                  state_nxt = LAUNCH;
      end
      WAIT_STOP: begin
        if (stop_s) begin
          state_nxt = IDLE;
        end else if (ctr_r == TO_LAST) begin
`ifdef I2C_SEQ_RETRY_EN
          if (!retry_r) state_nxt = LAUNCH;
          else          state_nxt = IDLE;
`else
          state_nxt = IDLE;
`endif
        end else begin
          state_nxt = WAIT_STOP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output/next-value logic for counter, enable, pulses and FIFO pop
  always_comb begin
    ctr_nxt    = ctr_r;
    enable_nxt = enable_r;
    done_nxt   = 1'b0;
    terr_nxt   = 1'b0;
    pop_s      = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
    retry_nxt  = retry_r;
`endif
    case (state_r)
      IDLE: begin
        if (count_r != {CNT_W{1'b0}}) begin
          pop_s      = 1'b1;
          enable_nxt = 1'b1;
          ctr_nxt    = 16'd0;
`ifdef I2C_SEQ_RETRY_EN
          retry_nxt  = 1'b0;
`endif
        end else begin
          pop_s = 1'b0;
        end
      end
      LAUNCH: begin
        if (ctr_r == EN_LAST) begin
          enable_nxt = 1'b0;
          ctr_nxt    = 16'd0;
        end else begin
          ctr_nxt = ctr_r + 16'd1;
        end
      end
      WAIT_STOP: begin
        if (stop_s) begin
          done_nxt = 1'b1;
          ctr_nxt  = 16'd0;
        end else if (ctr_r == TO_LAST) begin
          ctr_nxt = 16'd0;
`ifdef I2C_SEQ_RETRY_EN
          if (!retry_r) begin
            enable_nxt = 1'b1;
            retry_nxt  = 1'b1;
          end else begin
            terr_nxt = 1'b1;
          end
`else
          terr_nxt = 1'b1;
`endif
        end else begin
          ctr_nxt = ctr_r + 16'd1;
        end
      end
      default: begin
        ctr_nxt    = 16'd0;
        enable_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Scoreboard bench for i2c_cmd_sequencer: stimulus queues expected launches/completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_i2c_cmd_sequencer;

  localparam int DEPTH     = 4;
  localparam int EN_CYCLES = 5;
  localparam int TIMEOUT   = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       enable, rw, scl, sda, busy, txn_done, timeout_err;
  logic [6:0] address_in;
  logic [7:0] data_in;
  logic [2:0] fifo_count;

  int n_vec = 0;
  int n_err = 0;
  int cnt;
  int seen;

  logic [15:0] exp_launch[$];
  logic        exp_done[$];

  i2c_cmd_sequencer #(.DEPTH(DEPTH), .EN_CYCLES(EN_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_data(cmd_data),
    .enable(enable), .address_in(address_in), .rw(rw), .data_in(data_in),
    .scl(scl), .sda(sda), .busy(busy),
    .txn_done(txn_done), .timeout_err(timeout_err), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic push_cmd(input logic [6:0] a, input logic r, input logic [7:0] d);
    int g = 0;
    cmd_addr = a; cmd_rw = r; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && g < 500) begin @(negedge clk); g++; end
    if (!cmd_ready) begin
      fail_bound("push_wait");
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_launch.push_back({a, r, d});
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_en(input logic lvl, input string name);
    int g = 0;
    while (enable !== lvl && g < 200) begin @(negedge clk); g++; end
    if (enable !== lvl) fail_bound(name);
  endtask

  // Waits for WAIT_STOP, drives START then STOP, expects txn_done
  task automatic serve_stop();
    int g = 0;
    exp_done.push_back(1'b0);
    while (!(busy && !enable) && g < 200) begin @(negedge clk); g++; end
    if (!(busy && !enable)) fail_bound("serve_wait");
    sda = 1'b0;
    repeat (3) @(posedge clk);
    #1 sda = 1'b1;
    g = 0;
    while (!txn_done && g < 50) begin @(negedge clk); g++; end
    if (!txn_done) fail_bound("serve_done");
    check("done_busy_clear", 32'(busy), 32'd0);
  endtask

  // Monitor: launches, enable width, completion pulses
  initial begin
    logic        en_q;
    int          en_w;
    logic [15:0] e;
    logic        k;
    en_q = 1'b0;
    en_w = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        en_q = 1'b0;
        en_w = 0;
      end else begin
        if (enable && !en_q) begin
          if (exp_launch.size() == 0) begin
            fail_bound("launch_unexpected");
          end else begin
            e = exp_launch.pop_front();
            check("launch_cmd", 32'({address_in, rw, data_in}), 32'(e));
          end
        end
        if (enable) en_w++;
        if (!enable && en_q) begin
          check("enable_width", 32'(en_w), 32'(EN_CYCLES));
          en_w = 0;
        end
        if (txn_done || timeout_err) begin
          if (exp_done.size() == 0) begin
            fail_bound("pulse_unexpected");
          end else begin
            k = exp_done.pop_front();
            check("completion", 32'({txn_done, timeout_err}), k ? 32'd1 : 32'd2);
          end
        end
        en_q = enable;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_addr = 7'd0; cmd_rw = 1'b0; cmd_data = 8'd0;
    scl = 1'b1; sda = 1'b1;
    #3 rst_n = 1'b0;
    #2;
    check("rst_enable",      32'(enable),      32'd0);
    check("rst_cmd_ready",   32'(cmd_ready),   32'd1);
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_fifo_count",  32'(fifo_count),  32'd0);
    check("rst_txn_done",    32'(txn_done),    32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_launch_regs", 32'({address_in, rw, data_in}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single write, latency and payload
    push_cmd(7'b1100110, 1'b0, 8'hA5);
    check("t1_count_after_push", 32'(fifo_count), 32'd1);
    check("t1_enable_not_yet",   32'(enable),     32'd0);
    @(posedge clk); #1;
    check("t1_enable",   32'(enable),     32'd1);
    check("t1_busy",     32'(busy),       32'd1);
    check("t1_popped",   32'(fifo_count), 32'd0);
    check("t1_address",  32'(address_in), 32'h66);
    check("t1_data",     32'(data_in),    32'hA5);
    check("t1_rw",       32'(rw),         32'd0);
    serve_stop();

    // fill the FIFO behind an active command, fifth push waits for a pop
    push_cmd(7'h10, 1'b0, 8'h01);
    @(posedge clk); #1;
    push_cmd(7'h11, 1'b1, 8'h02);
    push_cmd(7'h12, 1'b0, 8'h03);
    push_cmd(7'h13, 1'b1, 8'h04);
    push_cmd(7'h14, 1'b0, 8'h05);
    check("t2_full_count", 32'(fifo_count), 32'd4);
    check("t2_full_ready", 32'(cmd_ready),  32'd0);
    repeat (2) @(negedge clk);
    check("t2_full_hold", 32'(cmd_ready), 32'd0);
    fork
      push_cmd(7'h15, 1'b1, 8'h06);
      for (int i = 0; i < 6; i++) serve_stop();
    join

`ifndef I2C_SEQ_RETRY_EN
    // timeout with no STOP, following command then launches
    exp_done.push_back(1'b1);
    push_cmd(7'h20, 1'b0, 8'h31);
    push_cmd(7'h21, 1'b1, 8'h32);
    wait_en(1'b1, "t3_rise");
    wait_en(1'b0, "t3_fall");
    cnt = 0;
    while (!timeout_err && cnt < 100) begin @(negedge clk); cnt++; end
    check("t3_timeout_latency", 32'(cnt), 32'(TIMEOUT));
    @(negedge clk);
    check("t3_pulse_width", 32'(timeout_err), 32'd0);
    check("t3_next_launch", 32'(enable),      32'd1);
    check("t3_next_addr",   32'(address_in),  32'h21);
    serve_stop();
`else
    // retry: two launches of the same command, a single timeout_err
    exp_done.push_back(1'b1);
    push_cmd(7'h22, 1'b1, 8'h33);
    exp_launch.push_back({7'h22, 1'b1, 8'h33});
    wait_en(1'b1, "t6_rise");
    wait_en(1'b0, "t6_fall");
    seen = 0;
    repeat (TIMEOUT) begin @(negedge clk); if (timeout_err) seen++; end
    check("t6_no_first_err", 32'(seen),       32'd0);
    check("t6_relaunch",     32'(enable),     32'd1);
    check("t6_same_addr",    32'(address_in), 32'h22);
    wait_en(1'b0, "t6_fall2");
    cnt = 0;
    while (!timeout_err && cnt < 100) begin @(negedge clk); cnt++; end
    check("t6_timeout_latency", 32'(cnt), 32'(TIMEOUT));
    @(negedge clk);
    check("t6_idle",        32'(busy),        32'd0);
    check("t6_pulse_width", 32'(timeout_err), 32'd0);
`endif

    // STOP lands on the last timeout cycle: STOP wins
    exp_done.push_back(1'b0);
    push_cmd(7'h2A, 1'b0, 8'h5C);
    wait_en(1'b1, "t4_rise");
    wait_en(1'b0, "t4_fall");
    sda = 1'b0;
    repeat (TIMEOUT - 3) @(posedge clk);
    #1 sda = 1'b1;
    cnt = 0;
    while (!(txn_done || timeout_err) && cnt < 50) begin @(negedge clk); cnt++; end
    check("t4_stop_latency", 32'(cnt),         32'd4);
    check("t4_txn_done",     32'(txn_done),    32'd1);
    check("t4_no_timeout",   32'(timeout_err), 32'd0);
    repeat (2) @(negedge clk);

    // asynchronous reset mid-transfer with three queued
    push_cmd(7'h30, 1'b1, 8'h41);
    @(posedge clk); #1;
    push_cmd(7'h31, 1'b0, 8'h42);
    push_cmd(7'h32, 1'b1, 8'h43);
    push_cmd(7'h33, 1'b0, 8'h44);
    check("t5_queued", 32'(fifo_count), 32'd3);
    cnt = 0;
    while (!(busy && !enable) && cnt < 100) begin @(negedge clk); cnt++; end
    if (!(busy && !enable)) fail_bound("t5_wait_stop");
    #2 rst_n = 1'b0;
    #1;
    check("t5_enable",     32'(enable),     32'd0);
    check("t5_fifo_count", 32'(fifo_count), 32'd0);
    check("t5_busy",       32'(busy),       32'd0);
    check("t5_cmd_ready",  32'(cmd_ready),  32'd1);
    exp_launch.delete();
    exp_done.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_still_idle", 32'(busy), 32'd0);

    check("end_launch_queue", 32'(exp_launch.size()), 32'd0);
    check("end_done_queue",   32'(exp_done.size()),   32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
